send_scheduler: RTL and testbench
=================================

Name: send_scheduler

Overview:
- Arbitrates between three packet sources and sequences the shared DataSender serializer.
- Sources are ACK, garbage-line packets and board-state update.
- Latches the winning ENC_DATA_BITS payload, issues a one-cycle send_start, waits for send_done, then enforces an inter-packet gap.
- Sits between the game/network logic and DataSender. Includes a watchdog so a stalled serializer cannot hang the link.

Parameters:
- DATA_BITS, 216, payload width; equals NetworkPkg ENC_DATA_BITS.
- N_REQ, 3, number of requesters; fixed at 3 for this revision.
- GAP_CYCLES, 4, idle cycles forced between packets; 0 is legal.
- TIMEOUT_CYCLES, 256, max cycles in SEND before abort; must be > DATA_BITS + 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  per-source request; held until accepted
- req_data  in  N_REQ*DATA_BITS  payloads; source i at bits [i*DATA_BITS +: DATA_BITS]
- req_ready  out  N_REQ  one-hot acceptance pulse (combinational from state/pointer/valid)
- send_start  out  1  one-cycle start pulse to DataSender
- data_out  out  DATA_BITS  latched payload to DataSender data_in
- send_done  in  1  DataSender completion
- busy  out  1  high in every state except IDLE
- grant_id  out  2  index of packet in flight; valid while busy
- pkt_done  out  1  one-cycle pulse: packet completed normally
- pkt_err  out  1  one-cycle pulse: packet aborted by watchdog
- done_id  out  2  source index qualifying pkt_done/pkt_err

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high.
- Reset values:
  - state = IDLE; rr_ptr = 0.
  - send_start, pkt_done, pkt_err, busy, req_ready = 0.
  - data_out, grant_id, done_id = 0.
  - Counters = 0.
- Reset mid-operation returns to IDLE next edge, with no pkt_done/pkt_err. The external DataSender is reset separately.

FSM states and transitions:
- IDLE:
  - Round-robin search starts at rr_ptr, wrapping modulo N_REQ. The first i with req_valid[i] is granted.
  - req_ready[i] = 1 in this cycle only; the handshake completes when valid and ready are both high.
  - On that edge: data_out <= req_data[i]; grant_id <= i; rr_ptr <= (i+1) mod N_REQ; state <= START.
  - No valid requests: stay in IDLE, req_ready = 0.
- START:
  - send_start = 1 for exactly one cycle; state <= SEND; tmo_cnt <= 0.
- SEND:
  - send_done = 1: state <= GAP (or IDLE if GAP_CYCLES == 0). Next cycle pkt_done = 1 and done_id = grant_id.
  - Otherwise, if tmo_cnt == TIMEOUT_CYCLES-1: same transition, but pkt_err pulses instead of pkt_done.
  - Otherwise tmo_cnt increments.
  - send_done and timeout in the same cycle: send_done wins, so pkt_done fires, not pkt_err.
- GAP:
  - Lasts exactly GAP_CYCLES cycles (gap_cnt from 0 to GAP_CYCLES-1), then IDLE.
- send_done is ignored outside SEND.
- data_out and grant_id are stable from the acceptance edge until the next acceptance.
- req_ready is 0 in every state except IDLE. Requests arriving while busy wait; they are not dropped.

Latency:
- Accept at cycle t → send_start at t+1 → SEND entered at t+2.
- send_done at cycle s → pkt_done at s+1.
- Earliest next req_ready is at s+1+GAP_CYCLES.
- Back-to-back throughput is one packet per (serializer time + 2 + GAP_CYCLES) cycles.

Test Plan:
- Single request: req_valid=3'b010, payload {108{2'b10}}.
  - Expect: req_ready=010 the same cycle; send_start 1 cycle later; data_out = payload.
  - Drive send_done 216 cycles later → pkt_done=1, done_id=1 next cycle.
  - IDLE is reached GAP_CYCLES=4 cycles after that.
- All three requests held high continuously.
  - Expect: grants in order 0,1,2,0,1,…
  - Expect: exactly one send_start per packet and req_ready one-hot.
- Timeout: grant source 2, never assert send_done.
  - Expect: pkt_err=1, done_id=2 at TIMEOUT_CYCLES+2 cycles after acceptance; pkt_done stays 0.
  - Expect: the next request is then accepted normally.
- Coincident done and timeout: assert send_done on the tmo_cnt == TIMEOUT_CYCLES-1 cycle.
  - Expect: pkt_done=1 and pkt_err=0.
- Reset during SEND: rst=1 for 1 cycle.
  - Expect: next cycle busy=0, send_start=0, no pkt_done/pkt_err, rr_ptr=0.
  - A pending req_valid=111 is then granted to source 0.
- GAP_CYCLES=0 build: send_done at s → req_ready for a pending request at s+1.

Source files
------------

// File: rtl/send_scheduler.sv
// Round-robin arbiter and sequencer for the shared DataSender serializer:
// latches the winning payload, pulses send_start, waits for send_done (with watchdog), then holds a gap.
module send_scheduler #(
    parameter int DATA_BITS      = 216,
    parameter int N_REQ          = 3,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DATA_BITS-1:0] req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       send_start,
    output logic [DATA_BITS-1:0]       data_out,
    input  logic                       send_done,
    output logic                       busy,
    output logic [1:0]                 grant_id,
    output logic                       pkt_done,
    output logic                       pkt_err,
    output logic [1:0]                 done_id
);

    // state | meaning
    // IDLE  | searching for a requester from rr_ptr, req_ready asserted on the winner
    // START | one-cycle send_start to the serializer
    // SEND  | waiting for send_done, watchdog tmo_cnt running
    // GAP   | forced idle time between packets
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [1:0]             state;
    logic [1:0]             rr_ptr;
    logic [TW-1:0]          tmo_cnt;
    logic [GW-1:0]          gap_cnt;

    logic [2*N_REQ-1:0]     valid_dbl;
    logic [N_REQ-1:0]       valid_rot;
    logic [1:0]             rot_off;
    logic [2:0]             idx_sum;
    logic [2:0]             ptr_sum;
    logic [1:0]             grant_idx;
    logic [1:0]             next_ptr;
    logic                   accept;
    logic [DATA_BITS-1:0]   sel_data;

    // Rotate the request vector so the search always starts at bit 0, then map back.
    always_comb begin
        valid_dbl = {req_valid, req_valid} >> rr_ptr;
        valid_rot = valid_dbl[N_REQ-1:0];
        rot_off   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (valid_rot[k]) rot_off = 2'(k);
        end
        idx_sum = {1'b0, rr_ptr} + {1'b0, rot_off};
        if (idx_sum >= 3'(N_REQ)) idx_sum = idx_sum - 3'(N_REQ);
        grant_idx = idx_sum[1:0];

        ptr_sum = {1'b0, grant_idx} + 3'd1;
        if (ptr_sum >= 3'(N_REQ)) ptr_sum = '0;
        next_ptr = ptr_sum[1:0];

        accept = (state == S_IDLE) && (|req_valid);

        sel_data  = '0;
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == 2'(i)) sel_data = req_data[i*DATA_BITS +: DATA_BITS];
            req_ready[i] = accept && (grant_idx == 2'(i));
        end
    end

    assign send_start = (state == S_START);
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            data_out <= '0;
            grant_id <= '0;
            done_id  <= '0;
            pkt_done <= 1'b0;
            pkt_err  <= 1'b0;
            tmo_cnt  <= '0;
            gap_cnt  <= '0;
        end else begin
            pkt_done <= 1'b0;
            pkt_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        data_out <= sel_data;
                        grant_id <= grant_idx;
                        rr_ptr   <= next_ptr;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    tmo_cnt <= '0;
                    state   <= S_SEND;
                end
                S_SEND: begin
                    // send_done takes priority over a watchdog expiry in the same cycle
                    if (send_done || (tmo_cnt == TMO_LAST)) begin
                        pkt_done <= send_done;
                        pkt_err  <= ~send_done;
                        done_id  <= grant_id;
                        gap_cnt  <= '0;
                        state    <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) state <= S_IDLE;
                    else gap_cnt <= gap_cnt + GW'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_send_scheduler.sv
// Bench for send_scheduler: timestamp-based packet model checked every cycle,
// plus directed scenarios with literal expectations and a GAP_CYCLES=0 instance.
module tb_send_scheduler;
    localparam int DB  = 216;
    localparam int NR  = 3;
    localparam int GAP = 4;
    localparam int TMO = 256;

    localparam logic [DB-1:0] P0 = {27{8'hA5}};
    localparam logic [DB-1:0] P1 = {108{2'b10}};
    localparam logic [DB-1:0] P2 = {27{8'h3C}};

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [NR*DB-1:0] req_data = {P2, P1, P0};
    logic [NR-1:0]   req_ready;
    logic            send_start;
    logic [DB-1:0]   data_out;
    logic            send_done = 1'b0;
    logic            busy;
    logic [1:0]      grant_id;
    logic            pkt_done;
    logic            pkt_err;
    logic [1:0]      done_id;

    logic [NR-1:0]   g_valid = '0;
    logic [NR-1:0]   g_ready;
    logic            g_start;
    logic [DB-1:0]   g_data_out;
    logic            g_done = 1'b0;
    logic            g_busy;
    logic [1:0]      g_grant_id;
    logic            g_pkt_done;
    logic            g_pkt_err;
    logic [1:0]      g_done_id;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    send_scheduler #(.DATA_BITS(DB), .N_REQ(NR), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .send_start(send_start), .data_out(data_out), .send_done(send_done), .busy(busy),
        .grant_id(grant_id), .pkt_done(pkt_done), .pkt_err(pkt_err), .done_id(done_id)
    );

    send_scheduler #(.DATA_BITS(DB), .N_REQ(NR), .GAP_CYCLES(0), .TIMEOUT_CYCLES(TMO)) u_gap0 (
        .clk(clk), .rst(rst), .req_valid(g_valid), .req_data(req_data), .req_ready(g_ready),
        .send_start(g_start), .data_out(g_data_out), .send_done(g_done), .busy(g_busy),
        .grant_id(g_grant_id), .pkt_done(g_pkt_done), .pkt_err(g_pkt_err), .done_id(g_done_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Packet-level model: each packet is described by its acceptance and end timestamps.
    bit            m_on = 1'b0;
    bit            m_busy = 1'b0;
    bit            m_pulse_ok = 1'b0;
    int            m_acc = -10;
    int            m_end = -1;
    int            m_pulse_cyc = -1;
    int            m_ptr = 0;
    int            m_grant = 0;
    int            m_done_id = 0;
    int            w;
    logic [DB-1:0] m_data = '0;
    logic [NR-1:0] e_ready;

    function automatic int pick(input int ptr, input logic [NR-1:0] v);
        int idx;
        for (int k = 0; k < NR; k++) begin
            idx = (ptr + k) % NR;
            if (v[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (m_on) begin
            if (m_busy && m_end >= 0 && cyc >= m_end + 1 + GAP) m_busy = 1'b0;
            w = pick(m_ptr, req_valid);
            e_ready = '0;
            if (!m_busy && w >= 0) e_ready = NR'(1) << w;
            check("req_ready", DB'(req_ready), DB'(e_ready));
            check("send_start", DB'(send_start), DB'(m_busy && cyc == m_acc + 1));
            check("busy", DB'(busy), DB'(m_busy));
            check("pkt_done", DB'(pkt_done), DB'(cyc == m_pulse_cyc && m_pulse_ok));
            check("pkt_err", DB'(pkt_err), DB'(cyc == m_pulse_cyc && !m_pulse_ok));
            check("grant_id", DB'(grant_id), DB'(m_grant));
            check("done_id", DB'(done_id), DB'(m_done_id));
            check("data_out", data_out, m_data);

            if (rst) begin
                m_busy = 1'b0; m_ptr = 0; m_grant = 0; m_done_id = 0;
                m_data = '0; m_pulse_cyc = -1; m_end = -1;
            end else if (m_busy) begin
                if (m_end < 0 && cyc >= m_acc + 2 && (send_done || cyc == m_acc + 1 + TMO)) begin
                    m_end = cyc;
                    m_pulse_cyc = cyc + 1;
                    m_pulse_ok = send_done;
                    m_done_id = m_grant;
                end
            end else if (w >= 0) begin
                m_busy = 1'b1;
                m_acc = cyc;
                m_end = -1;
                m_grant = w;
                m_data = DB'(req_data >> (w * DB));
                m_ptr = (w + 1) % NR;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #2;
    endtask

    // Called 1 time unit after a posedge; returns 3 units after the posedge of the cycle the event is seen.
    task automatic wait_ev(input string name, input bit want_ready, input int limit);
        int n;
        n = 0;
        #2;
        while (!(want_ready ? (|req_ready) : send_start) && n < limit) begin
            @(posedge clk);
            #3;
            n++;
        end
        checks++;
        if (!(want_ready ? (|req_ready) : send_start)) begin
            failures++;
            $display("FAIL %s cycle=%0d got=no event expected=event within %0d cycles", name, cyc, limit);
        end
    endtask

    // From the send_start cycle: k cycles into SEND, then one cycle of send_done.
    task automatic finish_pkt(input int k);
        repeat (k) step();
        send_done = 1'b1;
        step();
        send_done = 1'b0;
    endtask

    initial begin
        int exp_grant [6] = '{0, 1, 2, 0, 1, 2};
        logic [DB-1:0] pay [3] = '{P0, P1, P2};

        step();
        m_on = 1'b1;
        step();
        look();
        check("rst_busy", DB'(busy), DB'(1'b0));
        check("rst_data_out", data_out, '0);
        check("rst_done_id", DB'(done_id), DB'(2'd0));
        step();
        rst = 1'b0;

        // single request from source 1
        step();
        req_valid = 3'b010;
        look();
        check("single_ready", DB'(req_ready), DB'(3'b010));
        step();
        req_valid = '0;
        look();
        check("single_start", DB'(send_start), DB'(1'b1));
        check("single_data", data_out, P1);
        finish_pkt(215);
        look();
        check("single_pkt_done", DB'(pkt_done), DB'(1'b1));
        check("single_done_id", DB'(done_id), DB'(2'd1));
        repeat (3) step();
        look();
        check("gap_busy_last", DB'(busy), DB'(1'b1));
        step();
        look();
        check("gap_idle", DB'(busy), DB'(1'b0));

        // watchdog on source 2
        step();
        req_valid = 3'b100;
        look();
        check("tmo_ready", DB'(req_ready), DB'(3'b100));
        step();
        req_valid = '0;
        repeat (TMO + 1) step();
        look();
        check("tmo_pkt_err", DB'(pkt_err), DB'(1'b1));
        check("tmo_pkt_done", DB'(pkt_done), DB'(1'b0));
        check("tmo_done_id", DB'(done_id), DB'(2'd2));
        step();
        req_valid = 3'b001;
        wait_ev("after_tmo_accept", 1'b1, 20);
        check("after_tmo_ready", DB'(req_ready), DB'(3'b001));
        step();
        req_valid = '0;
        finish_pkt(5);

        // send_done coincident with watchdog expiry
        step();
        req_valid = 3'b010;
        wait_ev("coinc_accept", 1'b1, 20);
        check("coinc_ready", DB'(req_ready), DB'(3'b010));
        step();
        req_valid = '0;
        repeat (TMO) step();
        send_done = 1'b1;
        step();
        send_done = 1'b0;
        look();
        check("coinc_pkt_done", DB'(pkt_done), DB'(1'b1));
        check("coinc_pkt_err", DB'(pkt_err), DB'(1'b0));

        // reset in the middle of SEND with all sources pending
        step();
        req_valid = 3'b111;
        wait_ev("pre_rst_start", 1'b0, 20);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        look();
        check("rst_mid_busy", DB'(busy), DB'(1'b0));
        check("rst_mid_start", DB'(send_start), DB'(1'b0));
        check("rst_mid_pulse", DB'({pkt_done, pkt_err}), DB'(2'b00));
        check("rst_mid_ready", DB'(req_ready), DB'(3'b001));

        // all requests held: round-robin 0,1,2,0,1,2
        step();
        for (int p = 0; p < 6; p++) begin
            wait_ev("rr_start", 1'b0, 20);
            check("rr_grant", DB'(grant_id), DB'(exp_grant[p]));
            check("rr_data", data_out, pay[exp_grant[p]]);
            finish_pkt(3 + p);
        end
        req_valid = '0;
        repeat (8) step();

        // GAP_CYCLES=0 build: pending request is ready the cycle after send_done
        g_valid = 3'b101;
        look();
        check("g0_ready0", DB'(g_ready), DB'(3'b001));
        step();
        g_valid = 3'b100;
        look();
        check("g0_start", DB'(g_start), DB'(1'b1));
        check("g0_data", g_data_out, P0);
        step();
        step();
        g_done = 1'b1;
        step();
        g_done = 1'b0;
        look();
        check("g0_ready2", DB'(g_ready), DB'(3'b100));
        check("g0_pkt_done", DB'(g_pkt_done), DB'(1'b1));
        check("g0_pkt_err", DB'(g_pkt_err), DB'(1'b0));
        check("g0_done_id", DB'(g_done_id), DB'(2'd0));
        check("g0_busy", DB'(g_busy), DB'(1'b0));
        step();
        g_valid = '0;
        look();
        check("g0_grant2", DB'(g_grant_id), DB'(2'd2));
        step();
        g_done = 1'b1;
        step();
        g_done = 1'b0;
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout cycle=%0d got=running expected=finished", cyc);
        $fatal(1, "bench did not finish");
    end

endmodule
